cve2_multdiv_seq: RTL and testbench

CVE2_MULTDIV_SEQ -- requirements
Module: cve2_multdiv_seq

---
 rtl/cve2_pkg.sv | 11 +
 rtl/cve2_multdiv_seq.sv | 150 +++++++++++++++
 tb/tb_cve2_multdiv_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - multiply/divide operator encoding shared by the sequencer and its users
package cve2_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

endpackage

// File: rtl/cve2_multdiv_seq.sv
// rtl/cve2_multdiv_seq.sv - request/response sequencer in front of the slow multiply/divide unit
module cve2_multdiv_seq
   import cve2_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  md_op_e       req_operator_i,
   input  logic [1:0]   req_signed_mode_i,
   input  logic [31:0]  req_op_a_i,
   input  logic [31:0]  req_op_b_i,
   input  logic         flush_i,
   output logic         mult_en_o,
   output logic         div_en_o,
   output logic         mult_sel_o,
   output logic         div_sel_o,
   output md_op_e       operator_o,
   output logic [1:0]   signed_mode_o,
   output logic [31:0]  op_a_o,
   output logic [31:0]  op_b_o,
   input  logic [33:0]  imd_val_d_i [2],
   input  logic [1:0]   imd_val_we_i,
   output logic [33:0]  imd_val_q_o [2],
   output logic         multdiv_ready_id_o,
   input  logic         multdiv_valid_i,
   input  logic [31:0]  multdiv_result_i,
   output logic         rsp_valid_o,
   input  logic         rsp_ready_i,
   output logic [31:0]  rsp_result_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e        state_q;
   md_op_e        operator_q;
   logic [1:0]    signed_mode_q;
   logic [31:0]   op_a_q;
   logic [31:0]   op_b_q;
   logic [31:0]   result_q;
   logic          mult_en_q;
   logic          div_en_q;
   logic          busy_q;
   logic          rsp_valid_q;
   logic [33:0]   imd_q [2];
   logic          req_is_mul;
   logic          accept;

   assign req_is_mul = (req_operator_i == MD_OP_MULL) || (req_operator_i == MD_OP_MULH);

   // A completing response frees the slot in the same cycle, unless it is being flushed.
   assign req_ready_o = (state_q == ST_IDLE) ||
                        ((state_q == ST_DONE) && rsp_ready_i && !flush_i);
   assign accept      = req_valid_i && req_ready_o;

   // Sequencer FSM; unit enables, busy and response flags are registered alongside the state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         operator_q    <= MD_OP_MULL;
         signed_mode_q <= 2'b00;
         op_a_q        <= 32'd0;
         op_b_q        <= 32'd0;
         result_q      <= 32'd0;
         mult_en_q     <= 1'b0;
         div_en_q      <= 1'b0;
         busy_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
      end else if (accept) begin
         state_q       <= ST_RUN;
         operator_q    <= req_operator_i;
         signed_mode_q <= req_signed_mode_i;
         op_a_q        <= req_op_a_i;
         op_b_q        <= req_op_b_i;
         mult_en_q     <= req_is_mul;
         div_en_q      <= !req_is_mul;
         busy_q        <= 1'b1;
         rsp_valid_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (multdiv_valid_i) begin
                  mult_en_q <= 1'b0;
                  div_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  if (!flush_i) begin
                     result_q    <= multdiv_result_i;
                     rsp_valid_q <= 1'b1;
                     state_q     <= ST_DONE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (flush_i) begin
                  // Keep the unit enabled so it runs to completion and returns to idle.
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (multdiv_valid_i) begin
                  mult_en_q <= 1'b0;
                  div_en_q  <= 1'b0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (flush_i || rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Intermediate-value registers are written by the unit in any state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         imd_q[0] <= 34'd0;
         imd_q[1] <= 34'd0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (imd_val_we_i[i]) begin
               imd_q[i] <= imd_val_d_i[i];
            end
         end
      end
   end

   assign imd_val_q_o[0]     = imd_q[0];
   assign imd_val_q_o[1]     = imd_q[1];
   assign mult_en_o          = mult_en_q;
   assign mult_sel_o         = mult_en_q;
   assign div_en_o           = div_en_q;
   assign div_sel_o          = div_en_q;
   assign multdiv_ready_id_o = busy_q;
   assign operator_o         = operator_q;
   assign signed_mode_o      = signed_mode_q;
   assign op_a_o             = op_a_q;
   assign op_b_o             = op_b_q;
   assign rsp_valid_o        = rsp_valid_q;
   assign rsp_result_o       = result_q;

endmodule

// File: tb/tb_cve2_multdiv_seq.sv
// tb/tb_cve2_multdiv_seq.sv - randomized self-checking bench for the multdiv sequencer
module tb_cve2_multdiv_seq;
   import cve2_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   md_op_e        req_operator = MD_OP_MULL;
   logic [1:0]    req_sm = 2'b00;
   logic [31:0]   req_a = 32'd0;
   logic [31:0]   req_b = 32'd0;
   logic          flush = 1'b0;
   logic          mult_en, div_en, mult_sel, div_sel;
   md_op_e        operator_q;
   logic [1:0]    sm_q;
   logic [31:0]   op_a_q, op_b_q;
   logic [33:0]   imd_d [2];
   logic [1:0]    imd_we = 2'b00;
   logic [33:0]   imd_q [2];
   logic          ready_id;
   logic          md_valid = 1'b0;
   logic [31:0]   md_result = 32'd0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_result;

   int passed = 0;
   int total = 0;
   int unit_lat = 4;
   int unit_cnt = 0;
   logic [33:0] imd_m [2];

   always #5 clk = ~clk;

   cve2_multdiv_seq dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_operator_i(req_operator), .req_signed_mode_i(req_sm),
      .req_op_a_i(req_a), .req_op_b_i(req_b), .flush_i(flush),
      .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
      .operator_o(operator_q), .signed_mode_o(sm_q), .op_a_o(op_a_q), .op_b_o(op_b_q),
      .imd_val_d_i(imd_d), .imd_val_we_i(imd_we), .imd_val_q_o(imd_q),
      .multdiv_ready_id_o(ready_id), .multdiv_valid_i(md_valid), .multdiv_result_i(md_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result)
   );

   // Reference arithmetic on sign/zero-extended 64-bit operands.
   function automatic logic [31:0] ref_md(input int op, input logic [1:0] sm,
                                          input logic [31:0] a, input logic [31:0] b);
      longint ea, eb, r;
      ea = sm[0] ? longint'($signed(a)) : longint'({32'd0, a});
      eb = sm[1] ? longint'($signed(b)) : longint'({32'd0, b});
      r = 64'd0;
      case (op)
         0: r = ea * eb;
         1: begin r = ea * eb; r = r >>> 32; end
         2: r = (b == 32'd0) ? -64'sd1 : ea / eb;
         default: r = (b == 32'd0) ? ea : ea % eb;
      endcase
      return r[31:0];
   endfunction

   // Stand-in for the slow unit: result appears unit_lat cycles after enable.
   always @(negedge clk) begin
      if (!rst_n || !(mult_en || div_en)) begin
         unit_cnt = 0;
         md_valid = 1'b0;
      end else begin
         unit_cnt++;
         if (unit_cnt == unit_lat) begin
            md_valid  = 1'b1;
            md_result = ref_md(int'(operator_q), sm_q, op_a_q, op_b_q);
         end else begin
            md_valid = 1'b0;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int hold,
                         output logic [31:0] res, output int cyc, output bit stable);
      int g;
      unit_lat = lat;
      @(negedge clk);
      req_valid = 1'b1; req_operator = op; req_sm = sm; req_a = a; req_b = b; rsp_ready = 1'b0;
      #1;
      g = 0;
      while (!req_ready && g < 50) begin @(negedge clk); #1; g++; end
      @(negedge clk);
      req_valid = 1'b0;
      req_operator = md_op_e'(2'($urandom_range(0, 3)));
      req_a = $urandom; req_b = $urandom; req_sm = 2'($urandom_range(0, 3));
      cyc = 1;
      while (!rsp_valid && cyc < 200) begin @(negedge clk); cyc++; end
      res = rsp_result;
      stable = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         if (!rsp_valid || rsp_result !== res) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL post_reset_req_ready got %b want 1", req_ready); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
      total++; if ({mult_en, div_en, mult_sel, div_sel, ready_id} !== 5'b0)
         $display("FAIL reset_enables got %b want 00000", {mult_en, div_en, mult_sel, div_sel, ready_id}); else passed++;
      total++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result got %h want 0", rsp_result); else passed++;
      total++; if ({imd_q[0], imd_q[1], op_a_q, op_b_q} !== '0)
         $display("FAIL reset_state got imd %h/%h a %h b %h want 0", imd_q[0], imd_q[1], op_a_q, op_b_q); else passed++;
   endtask

   task automatic test_directed();
      logic [31:0] res; int cyc; bit st;
      run_op(MD_OP_MULL, 2'b00, 32'd6, 32'd7, 3, 0, res, cyc, st);
      total++; if (res !== 32'h0000002A) $display("FAIL mull_6x7 got %h want 0000002a", res); else passed++;
      total++; if (cyc !== 4) $display("FAIL mull_latency got %0d want 4", cyc); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL single_pulse got %b want 0", rsp_valid); else passed++;
      run_op(MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 9, 0, res, cyc, st);
      total++; if (res !== 32'hFFFFFFFD) $display("FAIL div_neg7_2 got %h want fffffffd", res); else passed++;
      run_op(MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 7, 1, res, cyc, st);
      total++; if (res !== 32'hFFFFFFFF) $display("FAIL rem_neg7_2 got %h want ffffffff", res); else passed++;
      run_op(MD_OP_REM, 2'b11, 32'd5, 32'd0, 2, 0, res, cyc, st);
      total++; if (res !== 32'h00000005) $display("FAIL rem_5_0 got %h want 00000005", res); else passed++;
   endtask

   task automatic test_random();
      logic [31:0] res, a, b, exp; int cyc, lat, hold, opi, r; bit st; logic [1:0] sm;
      for (int k = 0; k < 30; k++) begin
         opi = $urandom_range(0, 3);
         if (opi < 2) begin r = $urandom_range(0, 2); sm = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11); end
         else sm = $urandom_range(0, 1) ? 2'b11 : 2'b00;
         a = $urandom; b = $urandom;
         r = $urandom_range(0, 7);
         if (r == 0) b = 32'd0;
         else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         lat = $urandom_range(1, 10); hold = $urandom_range(0, 3);
         exp = ref_md(opi, sm, a, b);
         run_op(md_op_e'(2'(opi)), sm, a, b, lat, hold, res, cyc, st);
         total++; if (res !== exp) $display("FAIL rand_result[%0d] op %0d sm %b a %h b %h got %h want %h", k, opi, sm, a, b, res, exp); else passed++;
         total++; if (cyc !== lat + 1) $display("FAIL rand_latency[%0d] got %0d want %0d", k, cyc, lat + 1); else passed++;
         total++; if (!st) $display("FAIL rand_stable[%0d] got 0 want 1", k); else passed++;
         total++; if ({operator_q, sm_q, op_a_q, op_b_q} !== {2'(opi), sm, a, b})
            $display("FAIL rand_latched[%0d] got %0d %b %h %h want %0d %b %h %h", k, operator_q, sm_q, op_a_q, op_b_q, opi, sm, a, b); else passed++;
         total++; if (rsp_valid !== 1'b0) $display("FAIL rand_rsp_drop[%0d] got %b want 0", k, rsp_valid); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res; int g; bit st;
      unit_lat = 5;
      @(negedge clk);
      req_valid = 1'b1; req_operator = MD_OP_MULH; req_sm = 2'b11; req_a = 32'h80000000; req_b = 32'h80000000;
      @(negedge clk);
      req_valid = 1'b0;
      g = 0;
      while (!rsp_valid && g < 100) begin @(negedge clk); g++; end
      res = rsp_result; st = rsp_valid;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid || rsp_result !== res) st = 1'b0;
      end
      total++; if (res !== 32'h40000000) $display("FAIL mulh_min_sq got %h want 40000000", res); else passed++;
      total++; if (!st) $display("FAIL backpressure_stable got 0 want 1"); else passed++;
      total++; if (mult_en !== 1'b0) $display("FAIL done_mult_en got %b want 0", mult_en); else passed++;
      rsp_ready = 1'b1; req_valid = 1'b1; req_operator = MD_OP_MULL; req_sm = 2'b00; req_a = 32'd3; req_b = 32'd5;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL b2b_req_ready got %b want 1", req_ready); else passed++;
      @(negedge clk);
      rsp_ready = 1'b0; req_valid = 1'b0;
      total++; if ({rsp_valid, ready_id, mult_en, mult_sel} !== 4'b0111)
         $display("FAIL b2b_run got %b want 0111", {rsp_valid, ready_id, mult_en, mult_sel}); else passed++;
      total++; if (op_a_q !== 32'd3) $display("FAIL b2b_latched_a got %h want 3", op_a_q); else passed++;
      g = 0;
      while (!rsp_valid && g < 100) begin @(negedge clk); g++; end
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd15) $display("FAIL b2b_result got %b/%h want 1/0000000f", rsp_valid, rsp_result); else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_flush();
      logic [31:0] res; int cyc, g; bit st, seen;
      unit_lat = 20;
      @(negedge clk);
      req_valid = 1'b1; req_operator = MD_OP_DIV; req_sm = 2'b00; req_a = 32'd100; req_b = 32'd3;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++; if ({req_ready, ready_id, div_en, div_sel, rsp_valid} !== 5'b01110)
         $display("FAIL drain_outputs got %b want 01110", {req_ready, ready_id, div_en, div_sel, rsp_valid}); else passed++;
      seen = 1'b0; g = 0;
      while (!req_ready && g < 40) begin
         @(negedge clk); g++;
         if (rsp_valid) seen = 1'b1;
      end
      total++; if (req_ready !== 1'b1) $display("FAIL drain_to_idle got %b want 1", req_ready); else passed++;
      total++; if (seen !== 1'b0 || div_en !== 1'b0) $display("FAIL drain_no_rsp got rsp %b en %b want 0/0", seen, div_en); else passed++;
      run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd3, 3, 0, res, cyc, st);
      total++; if (res !== 32'h00000009) $display("FAIL after_flush_mull got %h want 00000009", res); else passed++;
      // Flush arriving in the same cycle as the unit's result.
      unit_lat = 4;
      @(negedge clk);
      req_valid = 1'b1; req_operator = MD_OP_MULL; req_sm = 2'b00; req_a = 32'd2; req_b = 32'd2;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++; if ({req_ready, rsp_valid, ready_id} !== 3'b100) $display("FAIL collide_idle got %b want 100", {req_ready, rsp_valid, ready_id}); else passed++;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) $display("FAIL collide_no_rsp got %b want 0", rsp_valid); else passed++;
   endtask

   task automatic test_done_flush();
      int g;
      flush = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL idle_flush_ready got %b want 1", req_ready); else passed++;
      @(negedge clk);
      flush = 1'b0;
      total++; if ({rsp_valid, mult_en, div_en, req_ready} !== 4'b0001) $display("FAIL idle_flush_state got %b want 0001", {rsp_valid, mult_en, div_en, req_ready}); else passed++;
      unit_lat = 2;
      req_valid = 1'b1; req_operator = MD_OP_MULL; req_sm = 2'b00; req_a = 32'd11; req_b = 32'd4;
      @(negedge clk);
      req_valid = 1'b0;
      g = 0;
      while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
      total++; if (rsp_result !== 32'd44) $display("FAIL done_flush_result got %h want 0000002c", rsp_result); else passed++;
      flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_a = 32'd99;
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL done_flush_ready got %b want 0", req_ready); else passed++;
      @(negedge clk);
      flush = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
      total++; if ({rsp_valid, req_ready, ready_id} !== 3'b010) $display("FAIL done_flush_idle got %b want 010", {rsp_valid, req_ready, ready_id}); else passed++;
      total++; if (op_a_q !== 32'd11) $display("FAIL done_flush_no_latch got %h want 0000000b", op_a_q); else passed++;
   endtask

   task automatic test_imd();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         imd_we = 2'($urandom_range(0, 3));
         for (int j = 0; j < 2; j++) begin
            imd_d[j] = {2'($urandom_range(0, 3)), 32'($urandom)};
            if (imd_we[j]) imd_m[j] = imd_d[j];
         end
         @(posedge clk);
         #1;
         total++; if (imd_q[0] !== imd_m[0] || imd_q[1] !== imd_m[1])
            $display("FAIL imd[%0d] got %h/%h want %h/%h", k, imd_q[0], imd_q[1], imd_m[0], imd_m[1]); else passed++;
      end
      @(negedge clk);
      imd_we = 2'b00;
   endtask

   task automatic test_reset_midrun();
      logic [31:0] res; int cyc; bit st, seen;
      unit_lat = 30;
      @(negedge clk);
      req_valid = 1'b1; req_operator = MD_OP_REM; req_sm = 2'b11; req_a = 32'd1000; req_b = 32'd7;
      @(negedge clk);
      req_valid = 1'b0;
      imd_we = 2'b11; imd_d[0] = 34'h2DEADBEEF; imd_d[1] = 34'h1CAFEF00D;
      @(negedge clk);
      imd_we = 2'b00;
      total++; if (imd_q[0] !== 34'h2DEADBEEF || imd_q[1] !== 34'h1CAFEF00D)
         $display("FAIL imd_in_run got %h/%h want 2deadbeef/1cafef00d", imd_q[0], imd_q[1]); else passed++;
      total++; if ({div_en, ready_id} !== 2'b11) $display("FAIL rem_running got %b want 11", {div_en, ready_id}); else passed++;
      rst_n = 1'b0;
      #1;
      seen = rsp_valid;
      total++; if ({req_ready, rsp_valid, mult_en, div_en, mult_sel, div_sel, ready_id} !== 7'b1000000)
         $display("FAIL midrun_reset_outputs got %b want 1000000", {req_ready, rsp_valid, mult_en, div_en, mult_sel, div_sel, ready_id}); else passed++;
      total++; if ({imd_q[0], imd_q[1], rsp_result, op_a_q, op_b_q} !== '0)
         $display("FAIL midrun_reset_regs got %h %h %h %h %h want 0", imd_q[0], imd_q[1], rsp_result, op_a_q, op_b_q); else passed++;
      repeat (2) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      rst_n = 1'b1;
      repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0 || req_ready !== 1'b1) $display("FAIL midrun_no_rsp got %b/%b want 0/1", seen, req_ready); else passed++;
      imd_m[0] = 34'd0; imd_m[1] = 34'd0;
      run_op(MD_OP_DIV, 2'b00, 32'd9, 32'd3, 6, 0, res, cyc, st);
      total++; if (res !== 32'h00000003) $display("FAIL after_reset_div got %h want 00000003", res); else passed++;
   endtask

   initial begin
      imd_d[0] = 34'd0; imd_d[1] = 34'd0;
      imd_m[0] = 34'd0; imd_m[1] = 34'd0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush();
      test_done_flush();
      test_imd();
      test_reset_midrun();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
